// File: rtl/core_ctrl_fsm_pkg.sv
// Shared control types for the multi-cycle RV32 sequencer, decoder and datapath muxes.
// Pure declarations: no latency, no flow control.
package core_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } ctrl_state_t;

  typedef enum logic [2:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5
  } inst_type_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC4  = 2'd1,
    WB_IMM  = 2'd2,
    WB_LOAD = 2'd3
  } wb_sel_t;

  typedef enum logic {
    PC_SEL_PC4 = 1'b0,
    PC_SEL_IMM = 1'b1
  } pc_sel_t;

  // Writeback source codes carried on wr_en[3:1].
  localparam logic [2:0] WB_SRC_ALU  = 3'd0;
  localparam logic [2:0] WB_SRC_PC4  = 3'd2;
  localparam logic [2:0] WB_SRC_IMM  = 3'd3;
  localparam logic [2:0] WB_SRC_LOAD = 3'd4;

  localparam logic [1:0] PC_JMP_NONE      = 2'b00;
  localparam logic [1:0] PC_JMP_ALWAYS    = 2'b01;
  localparam logic [1:0] PC_JMP_TAKEN     = 2'b10;
  localparam logic [1:0] PC_JMP_NOT_TAKEN = 2'b11;

  // Writeback control bundle captured on entry to WB.
  typedef struct packed {
    logic    rf_we;
    wb_sel_t wb_sel;
    pc_sel_t pc_sel;
  } wb_ctrl_t;

  function automatic wb_sel_t wb_sel_map(input logic [2:0] src);
    case (src)
      WB_SRC_ALU:  return WB_ALU;
      WB_SRC_PC4:  return WB_PC4;
      WB_SRC_IMM:  return WB_IMM;
      WB_SRC_LOAD: return WB_LOAD;
      default:     return WB_ALU;
    endcase
  endfunction

  function automatic pc_sel_t pc_sel_map(input logic [1:0] pc_jmp, input logic alu_flag);
    case (pc_jmp)
      PC_JMP_NONE:   return PC_SEL_PC4;
      PC_JMP_ALWAYS: return PC_SEL_IMM;
      PC_JMP_TAKEN:  return alu_flag ? PC_SEL_IMM : PC_SEL_PC4;
      default:       return alu_flag ? PC_SEL_PC4 : PC_SEL_IMM;
    endcase
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_mem_wait_timer.sv
// Counts cycles spent waiting on a memory ack; expired flags the tick that reaches TIMEOUT_CYC.
// Combinational expired, one-cycle registered count; no flow control.
module core_ctrl_fsm_mem_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick && (cnt != W'(TIMEOUT_CYC))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the wait cycle whose increment would reach TIMEOUT_CYC, so an ack in that
  // same cycle (tick low) still wins.
  assign expired = tick && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32 sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, TRAP on memory timeout.
// 4 cycles + fetch wait (5 + both waits for load/store); req held until ack, Moore strobes.
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_load,
  input  logic [2:0]  inst_type,
  input  logic [3:0]  wr_en,
  input  logic [1:0]  pc_jmp,
  input  logic        data_rd_en,
  input  logic        data_wr_en,
  input  logic [4:0]  rd,
  input  logic        alu_flag,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_load,
  output logic        pc_sel,
  output logic [31:0] retired,
  output logic        trap
);

  ctrl_state_t state;
  wb_ctrl_t    wb_nxt;
  logic        is_store;
  logic        is_branch;
  logic        timer_clear;
  logic        timer_tick;
  logic        timer_expired;

  always_comb begin
    is_store      = data_wr_en || (inst_type_t'(inst_type) == INST_S);
    is_branch     = pc_jmp[1] || (inst_type_t'(inst_type) == INST_B);
    wb_nxt.rf_we  = (wr_en[0] || (wr_en[3:1] == WB_SRC_LOAD)) && (rd != 5'd0)
                    && !is_store && !is_branch;
    wb_nxt.wb_sel = wb_sel_map(wr_en[3:1]);
    wb_nxt.pc_sel = pc_sel_map(pc_jmp, alu_flag);
  end

  // EXEC and WB both precede a wait state, so clearing there covers every FETCH/MEM entry.
  always_comb begin
    timer_clear = (state == EXEC) || (state == WB) || ((state == FETCH) && !imem_req);
    timer_tick  = ((state == FETCH) && imem_req && !imem_ack)
                || ((state == MEM) && dmem_req && !dmem_ack);
  end

  core_ctrl_fsm_mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      imem_req <= 1'b0;
      ir_load  <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      wb_sel   <= WB_ALU;
      pc_load  <= 1'b0;
      pc_sel   <= PC_SEL_PC4;
      retired  <= 32'd0;
      trap     <= 1'b0;
    end else begin
      ir_load <= 1'b0;
      rf_we   <= 1'b0;
      pc_load <= 1'b0;
      unique case (state)
        FETCH: begin
          // The cycle after reset only raises the request; acks count once it is visible.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            ir_load  <= 1'b1;
            state    <= DECODE;
          end else if (timer_expired) begin
            imem_req <= 1'b0;
            trap     <= 1'b1;
            state    <= TRAP;
          end
        end
        DECODE: begin
          state <= EXEC;
        end
        EXEC: begin
          if (data_rd_en || data_wr_en) begin
            dmem_req <= 1'b1;
            dmem_we  <= data_wr_en;
            state    <= MEM;
          end else begin
            rf_we   <= wb_nxt.rf_we;
            wb_sel  <= wb_nxt.wb_sel;
            pc_sel  <= wb_nxt.pc_sel;
            pc_load <= 1'b1;
            state   <= WB;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= wb_nxt.rf_we;
            wb_sel   <= wb_nxt.wb_sel;
            pc_sel   <= wb_nxt.pc_sel;
            pc_load  <= 1'b1;
            state    <= WB;
          end else if (timer_expired) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            trap     <= 1'b1;
            state    <= TRAP;
          end
        end
        WB: begin
          retired  <= retired + 32'd1;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          state    <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: instruction table through a writeback scoreboard plus
// hand-written reset, timeout and stray-ack sequences.
module tb_core_ctrl_fsm;
  import core_ctrl_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0, ir_load;
  logic [2:0]  inst_type = 3'd0;
  logic [3:0]  wr_en = 4'd0;
  logic [1:0]  pc_jmp = 2'd0;
  logic        data_rd_en = 1'b0, data_wr_en = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic        alu_flag = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        rf_we, pc_load, pc_sel, trap;
  logic [1:0]  wb_sel;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  core_ctrl_fsm #(.TIMEOUT_CYC(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .inst_type(inst_type), .wr_en(wr_en), .pc_jmp(pc_jmp), .data_rd_en(data_rd_en),
    .data_wr_en(data_wr_en), .rd(rd), .alu_flag(alu_flag), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_load(pc_load), .pc_sel(pc_sel), .retired(retired), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] itype;
    logic [3:0] wen;
    logic [1:0] pjmp;
    logic       lde;
    logic       ste;
    logic [4:0] rdi;
    logic       flag;
    int         iwait;
    int         dwait;
    logic       e_rf_we;
    logic [1:0] e_wb_sel;
    logic       e_pc_sel;
  } vec_t;

  typedef struct {
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_sel;
    logic        mem;
    logic        we;
    logic [31:0] retired;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_retired = 32'd0;
  logic        seen_mem = 1'b0, seen_we = 1'b0;
  vec_t        tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] it, input logic [3:0] we, input logic [1:0] pj,
                              input logic l, input logic s, input logic [4:0] r, input logic f,
                              input int iw, input int dw, input logic erf,
                              input logic [1:0] ewb, input logic epc);
    vec_t v;
    v.itype = it; v.wen = we; v.pjmp = pj; v.lde = l; v.ste = s; v.rdi = r; v.flag = f;
    v.iwait = iw; v.dwait = dw; v.e_rf_we = erf; v.e_wb_sel = ewb; v.e_pc_sel = epc;
    return v;
  endfunction

  task automatic wait_sig(input string name, input int which, input int limit);
    int n = 0;
    while (n < limit && !((which == 0) ? imem_req : dmem_req)) begin
      @(negedge clk);
      n++;
    end
    if (!((which == 0) ? imem_req : dmem_req)) chk(name, 0, 1);
  endtask

  task automatic drive_dec(input vec_t v);
    inst_type = v.itype; wr_en = v.wen; pc_jmp = v.pjmp; data_rd_en = v.lde;
    data_wr_en = v.ste; rd = v.rdi; alu_flag = v.flag;
  endtask

  // Runs one instruction to its WB cycle; the monitor compares the writeback outputs.
  task automatic do_instr(input vec_t v);
    exp_t e;
    int   n;
    wait_sig("fetch_req_timeout", 0, 20);
    drive_dec(v);
    e.rf_we = v.e_rf_we; e.wb_sel = v.e_wb_sel; e.pc_sel = v.e_pc_sel;
    e.mem = v.lde | v.ste; e.we = v.ste; e.retired = model_retired;
    sb.push_back(e);
    model_retired++;
    for (int i = 0; i < v.iwait; i++) begin imem_ack = 1'b0; @(negedge clk); end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ir_load_pulse", ir_load, 1);
    n = 1;
    if (v.lde || v.ste) begin
      while (!dmem_req && n < 10) begin @(negedge clk); n++; end
      for (int i = 0; i < v.dwait; i++) begin @(negedge clk); n++; end
      dmem_ack = 1'b1;
      @(negedge clk);
      n++;
      dmem_ack = 1'b0;
    end
    while (!pc_load && n < 40) begin @(negedge clk); n++; end
    chk("ack_to_wb_latency", n, (v.lde || v.ste) ? 4 + v.dwait : 3);
  endtask

  // Writeback monitor: pops one expectation per pc_load pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen_mem = 1'b0;
        seen_we  = 1'b0;
      end else begin
        if (dmem_req) begin
          seen_mem = 1'b1;
          seen_we  = dmem_we;
        end
        if (pc_load) begin
          if (sb.size() == 0) begin
            chk("unexpected_wb", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("wb_rf_we", rf_we, e.rf_we);
            chk("wb_sel", wb_sel, e.wb_sel);
            chk("wb_pc_sel", pc_sel, e.pc_sel);
            chk("wb_mem_access", seen_mem, e.mem);
            if (e.mem) chk("wb_dmem_we", seen_we, e.we);
            chk("wb_retired", retired, e.retired);
          end
          seen_mem = 1'b0;
          seen_we  = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t add1;
    tbl[0]  = mk(INST_R, 4'b0001, 2'b00, 0, 0, 5'd3,  0, 0,  0,  1, 2'd0, 0); // ADD x3
    tbl[1]  = mk(INST_B, 4'b0000, 2'b10, 0, 0, 5'd4,  1, 1,  0,  0, 2'd0, 1); // BEQ taken
    tbl[2]  = mk(INST_B, 4'b0000, 2'b11, 0, 0, 5'd4,  1, 0,  0,  0, 2'd0, 0); // BNE not taken
    tbl[3]  = mk(INST_J, 4'b0101, 2'b01, 0, 0, 5'd1,  0, 2,  0,  1, 2'd1, 1); // JAL x1
    tbl[4]  = mk(INST_I, 4'b1001, 2'b00, 1, 0, 5'd5,  0, 0,  3,  1, 2'd3, 0); // LW x5
    tbl[5]  = mk(INST_S, 4'b0000, 2'b00, 0, 1, 5'd9,  0, 1,  0,  0, 2'd0, 0); // SW
    tbl[6]  = mk(INST_I, 4'b0001, 2'b00, 0, 0, 5'd0,  0, 0,  0,  0, 2'd0, 0); // ADDI x0
    tbl[7]  = mk(INST_U, 4'b0111, 2'b00, 0, 0, 5'd7,  0, 0,  0,  1, 2'd2, 0); // LUI x7
    tbl[8]  = mk(INST_B, 4'b0000, 2'b10, 0, 0, 5'd4,  0, 0,  0,  0, 2'd0, 0); // BEQ not taken
    tbl[9]  = mk(INST_B, 4'b0000, 2'b11, 0, 0, 5'd4,  0, 0,  0,  0, 2'd0, 1); // BNE taken
    tbl[10] = mk(INST_I, 4'b1000, 2'b00, 1, 0, 5'd2,  0, 0,  1,  1, 2'd3, 0); // load, wr_en[0]=0
    tbl[11] = mk(INST_R, 4'b1111, 2'b00, 0, 0, 5'd6,  0, 0,  0,  1, 2'd0, 0); // unknown src
    tbl[12] = mk(INST_S, 4'b0001, 2'b00, 0, 1, 5'd8,  0, 0,  0,  0, 2'd0, 0); // store ignores wr_en
    tbl[13] = mk(INST_B, 4'b0001, 2'b10, 0, 0, 5'd10, 1, 0,  0,  0, 2'd0, 1); // branch never writes
    tbl[14] = mk(INST_R, 4'b0001, 2'b00, 0, 0, 5'd12, 0, 15, 0,  1, 2'd0, 0); // imem ack on 16th
    tbl[15] = mk(INST_S, 4'b0000, 2'b00, 0, 1, 5'd0,  0, 0,  15, 0, 2'd0, 0); // dmem ack on 16th
    tbl[16] = mk(INST_J, 4'b0101, 2'b01, 0, 0, 5'd0,  0, 0,  0,  0, 2'd1, 1); // JAL x0
    add1 = tbl[0];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_strobes", {ir_load, rf_we, pc_load, dmem_we}, 4'b0000);
    chk("rst_sel", {wb_sel, pc_sel}, 3'b000);
    chk("rst_retired", retired, 0);
    chk("rst_trap", trap, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fetch_req", imem_req, 1);

    foreach (tbl[i]) do_instr(tbl[i]);
    @(negedge clk);
    chk("table_no_trap", trap, 0);
    chk("table_retired", retired, model_retired);
    chk("table_sb_drained", sb.size(), 0);

    // dmem_ack while fetching must not advance
    wait_sig("fetch_req_timeout", 0, 20);
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fetch_ignores_dmem_ack", {imem_req, ir_load, pc_load}, 3'b100);
    end
    dmem_ack = 1'b0;
    do_instr(tbl[3]);

    // Reset in MEM with a pending ack
    wait_sig("fetch_req_timeout", 0, 20);
    drive_dec(tbl[4]);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    wait_sig("dmem_req_timeout", 1, 10);
    @(negedge clk);
    chk("mem_req_before_rst", dmem_req, 1);
    rst = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_retired = 32'd0;
    chk("rst_mem_dmem_req", dmem_req, 0);
    chk("rst_mem_retired", retired, 0);
    chk("rst_mem_trap", trap, 0);
    chk("rst_mem_sel", {wb_sel, pc_sel}, 3'b000);
    repeat (2) @(negedge clk);
    dmem_ack = 1'b0;
    chk("rst_mem_stale_ack", {imem_req, dmem_req, pc_load, rf_we}, 4'b1000);

    // Fetch timeout -> absorbing trap with retired frozen
    do_instr(add1);
    wait_sig("fetch_req_timeout", 0, 20);
    repeat (15) @(negedge clk);
    chk("imem_wait_16_no_trap", {trap, imem_req}, 2'b01);
    @(negedge clk);
    chk("imem_timeout_trap", trap, 1);
    chk("imem_timeout_req", imem_req, 0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk("trap_absorbing", {trap, imem_req, dmem_req, ir_load, pc_load, rf_we}, 6'b100000);
    chk("trap_retired_frozen", retired, model_retired);

    // Data timeout
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_retired = 32'd0;
    chk("rst_clears_trap", trap, 0);
    wait_sig("fetch_req_timeout", 0, 20);
    drive_dec(tbl[5]);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    wait_sig("dmem_req_timeout", 1, 10);
    repeat (15) @(negedge clk);
    chk("dmem_wait_16_no_trap", {trap, dmem_req, dmem_we}, 3'b011);
    @(negedge clk);
    chk("dmem_timeout_trap", {trap, dmem_req, dmem_we, imem_req}, 4'b1000);
    chk("dmem_timeout_retired", retired, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("final_rst_trap", trap, 0);
    chk("final_sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
